rvv_issue_ctrl: RTL and testbench



---
 rtl/rvv_pkg.sv | 43 ++++
 rtl/rvv_issue_ctrl_if.sv | 29 ++
 rtl/rvv_insn_fifo.sv | 46 ++++
 rtl/rvv_issue_ctrl.sv | 84 ++++++++
 tb/tb_rvv_issue_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvv_pkg.sv
// rtl/rvv_pkg.sv - opcode constants, decoded operand record and head decoder
package rvv_pkg;

    localparam logic [6:0] OPV     = 7'h57;
    localparam logic [6:0] LOADFP  = 7'h07;
    localparam logic [6:0] STOREFP = 7'h27;
    localparam logic [2:0] OPCFG   = 3'b111;

    // vs3 shares the vd field, so it is not stored separately
    typedef struct packed {
        logic       rd_vs1;
        logic       rd_vs2;
        logic       rd_vs3;
        logic       wr_vd;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
    } decoded_t;

    // Vector operand usage of one instruction; unknown opcodes touch nothing
    function automatic decoded_t decode(input logic [31:0] insn);
        decoded_t d;
        d     = '0;
        d.vd  = insn[11:7];
        d.vs1 = insn[19:15];
        d.vs2 = insn[24:20];
        case (insn[6:0])
            OPV: begin
                if (insn[14:12] != OPCFG) begin
                    d.wr_vd  = 1'b1;
                    d.rd_vs2 = 1'b1;
                    // OPIVV, OPFVV and OPMVV are the vector-vector forms
                    d.rd_vs1 = (insn[14:12] <= 3'b010);
                end
            end
            LOADFP:  d.wr_vd  = 1'b1;
            STOREFP: d.rd_vs3 = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rvv_issue_ctrl_if.sv
// rtl/rvv_issue_ctrl_if.sv - host, issue and writeback signals of the issue controller
interface rvv_issue_ctrl_if #(
    parameter int INSN_WIDTH = 32,
    parameter int NUM_VEC    = 32
);
    localparam int VW = $clog2(NUM_VEC);

    logic [INSN_WIDTH-1:0] host_insn_in;
    logic                  host_valid_in;
    logic                  host_ready_out;
    logic [INSN_WIDTH-1:0] insn_out;
    logic                  insn_valid_out;
    logic                  proc_rdy_in;
    logic                  wb_valid_in;
    logic [VW-1:0]         wb_vreg_in;
    logic                  flush_in;
    logic                  busy_out;
    logic [31:0]           stall_cnt_out;

    modport master (
        output host_insn_in, host_valid_in, proc_rdy_in, wb_valid_in, wb_vreg_in, flush_in,
        input  host_ready_out, insn_out, insn_valid_out, busy_out, stall_cnt_out
    );

    modport slave (
        input  host_insn_in, host_valid_in, proc_rdy_in, wb_valid_in, wb_vreg_in, flush_in,
        output host_ready_out, insn_out, insn_valid_out, busy_out, stall_cnt_out
    );
endinterface

// File: rtl/rvv_insn_fifo.sv
// rtl/rvv_insn_fifo.sv - instruction buffer with wrap-bit pointers
module rvv_insn_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset: the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; flush drops every entry at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/rvv_issue_ctrl.sv
// rtl/rvv_issue_ctrl.sv - hazard-checked instruction issue toward the vector processor
module rvv_issue_ctrl
    import rvv_pkg::*;
#(
    parameter int INSN_WIDTH = 32,
    parameter int NUM_VEC    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    rvv_issue_ctrl_if.slave bus
);
    localparam int VW = $clog2(NUM_VEC);

    logic [INSN_WIDTH-1:0] head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  hazard;
    logic                  issue_ok;
    decoded_t              dec;
    logic [NUM_VEC-1:0]    sb;
    logic [NUM_VEC-1:0]    sb_set;
    logic [NUM_VEC-1:0]    sb_clr;
    logic [31:0]           stall_cnt;

    rvv_insn_fifo #(
        .WIDTH (INSN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush_in),
        .wdata (bus.host_insn_in),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign dec = decode(head[31:0]);

    // Checked against the registered scoreboard only: writeback is never bypassed
    assign hazard = (dec.rd_vs1 && sb[dec.vs1[VW-1:0]])
                 || (dec.rd_vs2 && sb[dec.vs2[VW-1:0]])
                 || (dec.rd_vs3 && sb[dec.vd[VW-1:0]])
                 || (dec.wr_vd  && sb[dec.vd[VW-1:0]]);

    // Ready also drops during flush so the host never sees a dropped handshake
    assign bus.host_ready_out = !full && !bus.flush_in;
    assign push               = bus.host_valid_in && bus.host_ready_out;
    assign issue_ok           = !empty && !hazard && !bus.flush_in;
    assign pop                = issue_ok && bus.proc_rdy_in;

    assign bus.insn_out       = head;
    assign bus.insn_valid_out = issue_ok;
    assign bus.busy_out       = !empty || (|sb);
    assign bus.stall_cnt_out  = stall_cnt;

    assign sb_set = (pop && dec.wr_vd) ? (NUM_VEC'(1) << dec.vd[VW-1:0]) : '0;
    assign sb_clr = bus.wb_valid_in    ? (NUM_VEC'(1) << bus.wb_vreg_in)  : '0;

    // Pending-write scoreboard; a same-cycle set overrides the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else if (bus.flush_in) begin
            sb <= '0;
        end else begin
            sb <= (sb & ~sb_clr) | sb_set;
        end
    end

    // Saturating count of cycles the head sat behind a hazard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!empty && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_rvv_issue_ctrl.sv
// tb/tb_rvv_issue_ctrl.sv - self-checking bench for rvv_issue_ctrl
module tb_rvv_issue_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rvv_issue_ctrl_if #(.INSN_WIDTH(32), .NUM_VEC(32)) bus ();

    rvv_issue_ctrl #(
        .INSN_WIDTH (32),
        .NUM_VEC    (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] insn;
        bit          haz;
    } vec_t;

    vec_t tbl[12];

    // Reference model state
    logic [31:0] mq[$];
    bit   [31:0] msb;
    int unsigned mcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] opv(input logic [2:0] f3, input logic [4:0] vd,
                                        input logic [4:0] vs1, input logic [4:0] vs2);
        return {7'b0000001, vs2, vs1, f3, vd, 7'h57};
    endfunction

    function automatic logic [31:0] ldfp(input logic [4:0] vd, input logic [4:0] oth);
        return {7'b0, oth, oth, 3'b000, vd, 7'h07};
    endfunction

    function automatic logic [31:0] stfp(input logic [4:0] vs3, input logic [4:0] oth);
        return {7'b0, oth, oth, 3'b000, vs3, 7'h27};
    endfunction

    function automatic logic [31:0] other(input logic [4:0] r);
        return {7'b0, r, r, 3'b000, r, 7'h13};
    endfunction

    // Registers each instruction reads or writes, straight from the operand rules
    function automatic bit m_haz(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        int         regs[$];
        op = i[6:0];
        f3 = i[14:12];
        if (op == 7'h57 && f3 != 3'b111) begin
            regs.push_back(int'(i[11:7]));
            regs.push_back(int'(i[24:20]));
            if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) regs.push_back(int'(i[19:15]));
        end else if (op == 7'h07 || op == 7'h27) begin
            regs.push_back(int'(i[11:7]));
        end
        foreach (regs[k]) if (msb[regs[k]]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_writes(input logic [31:0] i);
        return (i[6:0] == 7'h07) || (i[6:0] == 7'h57 && i[14:12] != 3'b111);
    endfunction

    task automatic drive_idle();
        bus.host_insn_in  = '0;
        bus.host_valid_in = 1'b0;
        bus.proc_rdy_in   = 1'b0;
        bus.wb_valid_in   = 1'b0;
        bus.wb_vreg_in    = '0;
        bus.flush_in      = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push1(input logic [31:0] insn);
        bus.host_insn_in  = insn;
        bus.host_valid_in = 1'b1;
        tick();
        bus.host_valid_in = 1'b0;
    endtask

    task automatic random_run(input int cycles);
        logic [31:0] ri;
        bit          e_valid;
        bit          e_ready;
        bit          e_busy;
        bit          h;
        bit          set_now;
        logic [31:0] head;
        int          f;
        do_reset();
        mq.delete();
        msb  = '0;
        mcnt = 0;
        for (int c = 0; c < cycles; c++) begin
            f = int'($urandom_range(0, 4));
            case (f)
                0: ri = opv(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                1: ri = ldfp(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                2: ri = stfp(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                3: ri = other(5'($urandom_range(0, 7)));
                default: ri = opv(3'($urandom_range(0, 2)), 5'($urandom_range(0, 7)),
                                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            endcase
            bus.host_insn_in  = ri;
            bus.host_valid_in = ($urandom_range(0, 99) < 60);
            bus.proc_rdy_in   = ($urandom_range(0, 99) < 70);
            bus.wb_valid_in   = ($urandom_range(0, 99) < 35);
            bus.wb_vreg_in    = 5'($urandom_range(0, 7));
            bus.flush_in      = ($urandom_range(0, 99) < 2);
            #1;
            head    = (mq.size() > 0) ? mq[0] : '0;
            h       = (mq.size() > 0) && m_haz(head);
            e_valid = (mq.size() > 0) && !h && !bus.flush_in;
            e_ready = (mq.size() < 4) && !bus.flush_in;
            e_busy  = (mq.size() > 0) || (msb != '0);
            chk("rand_valid", 32'(bus.insn_valid_out), 32'(e_valid));
            chk("rand_ready", 32'(bus.host_ready_out), 32'(e_ready));
            chk("rand_busy",  32'(bus.busy_out),       32'(e_busy));
            chk("rand_stall", bus.stall_cnt_out,       mcnt);
            if (e_valid) chk("rand_insn", bus.insn_out, head);
            if (h && mcnt != 32'hFFFF_FFFF) mcnt++;
            if (bus.flush_in) begin
                mq.delete();
                msb = '0;
            end else begin
                set_now = 1'b0;
                if (e_valid && bus.proc_rdy_in) begin
                    head = mq.pop_front();
                    if (m_writes(head)) set_now = 1'b1;
                end
                if (bus.wb_valid_in) msb[bus.wb_vreg_in] = 1'b0;
                if (set_now) msb[head[11:7]] = 1'b1;
                if (bus.host_valid_in && e_ready) mq.push_back(bus.host_insn_in);
            end
            @(posedge clk);
            #1;
        end
        drive_idle();
    endtask

    logic [31:0] xs[5];

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0]  = '{"opv_vv_vs1",    opv(3'b000, 5'd5, 5'd3, 5'd4), 1'b1};
        tbl[1]  = '{"opv_vi_novs1",  opv(3'b011, 5'd5, 5'd3, 5'd4), 1'b0};
        tbl[2]  = '{"opv_vx_vs2",    opv(3'b100, 5'd5, 5'd1, 5'd3), 1'b1};
        tbl[3]  = '{"opv_waw",       opv(3'b010, 5'd3, 5'd1, 5'd2), 1'b1};
        tbl[4]  = '{"opv_vset",      opv(3'b111, 5'd3, 5'd3, 5'd3), 1'b0};
        tbl[5]  = '{"ldfp_waw",      ldfp(5'd3, 5'd0), 1'b1};
        tbl[6]  = '{"ldfp_noread",   ldfp(5'd6, 5'd3), 1'b0};
        tbl[7]  = '{"stfp_vs3",      stfp(5'd3, 5'd0), 1'b1};
        tbl[8]  = '{"stfp_other",    stfp(5'd4, 5'd3), 1'b0};
        tbl[9]  = '{"other_opcode",  other(5'd3), 1'b0};
        tbl[10] = '{"opv_mvv_vs1",   opv(3'b001, 5'd8, 5'd3, 5'd7), 1'b1};
        tbl[11] = '{"opv_f6_novs1",  opv(3'b110, 5'd8, 5'd3, 5'd7), 1'b0};

        // Reset values while held
        drive_idle();
        rst_n = 1'b0;
        tick();
        chk("rst_valid", 32'(bus.insn_valid_out), 32'd0);
        chk("rst_ready", 32'(bus.host_ready_out), 32'd1);
        chk("rst_busy",  32'(bus.busy_out),       32'd0);
        chk("rst_stall", bus.stall_cnt_out,       32'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-stream with two entries queued
        push1(other(5'd1));
        push1(other(5'd2));
        chk("mid_busy_before", 32'(bus.busy_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(bus.insn_valid_out), 32'd0);
        chk("mid_busy",  32'(bus.busy_out),       32'd0);
        chk("mid_ready", 32'(bus.host_ready_out), 32'd1);
        tick();
        rst_n = 1'b1;

        // Operand decode table against a pending write to v3
        for (int t = 0; t < 12; t++) begin
            do_reset();
            bus.proc_rdy_in = 1'b1;
            push1(ldfp(5'd3, 5'd0));
            push1(tbl[t].insn);
            chk({tbl[t].name, "_valid"}, 32'(bus.insn_valid_out), 32'(!tbl[t].haz));
            chk({tbl[t].name, "_insn"},  bus.insn_out,            tbl[t].insn);
            tick();
            tick();
            tick();
            chk({tbl[t].name, "_stall"}, bus.stall_cnt_out, tbl[t].haz ? 32'd3 : 32'd0);
        end

        // Independent stream: one issue per cycle, in order
        do_reset();
        xs[0] = 32'h022081D7;
        xs[1] = opv(3'b000, 5'd6, 5'd4, 5'd5);
        xs[2] = opv(3'b000, 5'd9, 5'd7, 5'd8);
        xs[3] = opv(3'b000, 5'd12, 5'd10, 5'd11);
        bus.proc_rdy_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.host_insn_in  = xs[k];
            bus.host_valid_in = 1'b1;
            tick();
            chk("indep_valid", 32'(bus.insn_valid_out), 32'd1);
            chk("indep_insn",  bus.insn_out,            xs[k]);
        end
        bus.host_valid_in = 1'b0;
        tick();
        chk("indep_drained", 32'(bus.insn_valid_out), 32'd0);

        // RAW hold released by writeback of v3
        do_reset();
        bus.proc_rdy_in = 1'b1;
        push1(32'h022081D7);
        push1(32'h023202D7);
        chk("raw_held",   32'(bus.insn_valid_out), 32'd0);
        chk("raw_stall0", bus.stall_cnt_out,       32'd0);
        tick();
        tick();
        tick();
        chk("raw_stall3", bus.stall_cnt_out, 32'd3);
        bus.wb_valid_in = 1'b1;
        bus.wb_vreg_in  = 5'd3;
        #1;
        chk("raw_no_bypass", 32'(bus.insn_valid_out), 32'd0);
        tick();
        bus.wb_valid_in = 1'b0;
        chk("raw_release", 32'(bus.insn_valid_out), 32'd1);
        chk("raw_insn",    bus.insn_out,            32'h023202D7);
        chk("raw_stall4",  bus.stall_cnt_out,       32'd4);

        // Full: fifth push refused, then four drain in order
        do_reset();
        for (int k = 0; k < 5; k++) xs[k] = other(5'(k + 1));
        for (int k = 0; k < 5; k++) begin
            chk("full_ready", 32'(bus.host_ready_out), (k < 4) ? 32'd1 : 32'd0);
            push1(xs[k]);
        end
        bus.proc_rdy_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("full_valid", 32'(bus.insn_valid_out), 32'd1);
            chk("full_insn",  bus.insn_out,            xs[k]);
            tick();
        end
        chk("full_fifth_dropped", 32'(bus.insn_valid_out), 32'd0);

        // Same-cycle set and clear of v3: set wins
        do_reset();
        bus.proc_rdy_in = 1'b1;
        push1(ldfp(5'd3, 5'd0));
        bus.wb_valid_in = 1'b1;
        bus.wb_vreg_in  = 5'd3;
        push1(stfp(5'd3, 5'd0));
        bus.wb_valid_in = 1'b0;
        chk("setclr_stall", 32'(bus.insn_valid_out), 32'd0);
        chk("setclr_busy",  32'(bus.busy_out),       32'd1);
        tick();
        chk("setclr_still", 32'(bus.insn_valid_out), 32'd0);
        bus.wb_valid_in = 1'b1;
        tick();
        bus.wb_valid_in = 1'b0;
        chk("setclr_release", 32'(bus.insn_valid_out), 32'd1);

        // Flush with three queued and v3 pending
        do_reset();
        bus.proc_rdy_in = 1'b1;
        push1(ldfp(5'd3, 5'd0));
        push1(other(5'd1));
        bus.proc_rdy_in = 1'b0;
        push1(other(5'd2));
        push1(other(5'd4));
        chk("flush_pre_valid", 32'(bus.insn_valid_out), 32'd1);
        bus.flush_in = 1'b1;
        #1;
        chk("flush_valid", 32'(bus.insn_valid_out), 32'd0);
        tick();
        bus.flush_in = 1'b0;
        #1;
        chk("flush_busy",  32'(bus.busy_out),       32'd0);
        chk("flush_empty", 32'(bus.insn_valid_out), 32'd0);

        // Randomised traffic against the queue model
        random_run(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
